usb_rx_phy: RTL
===============

USB_RX_PHY -- requirements
Module: usb_rx_phy

Interface
REQ-001 Parameter: SYNC_ZEROS, default 6, minimum run of decoded 0s that must precede the decoded 1 closing the sync field.
REQ-002 Parameter: STUFF_LEN, default 6, run of decoded 1s after which the next bit is a stuffed bit.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low; the ports are named clk and rst.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst  in  1  asynchronous active-low reset.
REQ-006 Port: bit_en  in  1  sample strobe, high for one clk per bit time; all line sampling occurs only on bit_en.
REQ-007 Port: rxd  in  1  received line level (1 = J, 0 = K); ignored when se0 = 1.
REQ-008 Port: se0  in  1  single-ended-zero line state.
REQ-009 Port: DataIn_o  out  8  last fully received byte.
REQ-010 Port: RxValid_o  out  1  one-clk pulse when DataIn_o is updated.
REQ-011 Port: RxActive_o  out  1  high from sync detect until end of EOP.
REQ-012 Port: RxError_o  out  1  one-clk pulse on a bit-stuff violation.

Function
REQ-013 NRZI decode, on bit_en with se0 = 0: decoded bit = 1 if rxd equals last_rxd, else 0; last_rxd <= rxd.
REQ-014 On bit_en with se0 = 1: last_rxd <= 1 (J); no decoded bit is produced.
REQ-015 States: IDLE, DATA, ERR, EOP; all transitions occur only on bit_en.
REQ-016 IDLE: count consecutive decoded 0s, saturating at SYNC_ZEROS; a decoded 1 clears the count.
REQ-017 IDLE to DATA: a decoded 1 arrives with zero count >= SYNC_ZEROS; in the same cycle set RxActive_o = 1, ones count = 1, bit count = 0.
REQ-018 DATA, when the ones count equals STUFF_LEN: the current bit is a stuff bit.
- decoded 0: discard it, clear the ones count.
- decoded 1: pulse RxError_o, go to ERR.
REQ-019 DATA, non-stuff decoded bit: shift it in LSB-first; decoded 1 increments the ones count, decoded 0 clears it; bit count increments modulo 8.
REQ-020 On the bit_en that completes the 8th kept bit, in the following clk cycle:
- DataIn_o <= assembled byte;
- RxValid_o = 1 for exactly that one cycle.
REQ-021 DataIn_o holds its value until the next completed byte.
REQ-022 DATA with se0 = 1 on bit_en: go to EOP; any partial byte (bit count 1..7) is silently discarded, with no RxValid_o and no RxError_o.
REQ-023 ERR: ignore all data; se0 = 1 on bit_en moves to EOP; RxActive_o stays 1.
REQ-024 EOP: first bit_en with se0 = 0 moves to IDLE and clears RxActive_o in the same cycle; that bit is not used for sync counting, and the zero count restarts at 0.
REQ-025 IDLE ignores se0, except that last_rxd is forced to J per REQ-014.
REQ-026 Simultaneous events: a stuff-bit error takes priority over byte completion; byte completion is impossible on a se0 bit.
REQ-027 Cycles without bit_en: all state and outputs hold, except that RxValid_o and RxError_o return to 0.

Reset
REQ-028 While rst = 0, asynchronously force:
- state = IDLE, last_rxd = 1;
- all counters = 0;
- DataIn_o = 8'h00, RxValid_o = 0, RxActive_o = 0, RxError_o = 0.
REQ-029 Reset asserted mid-packet aborts the packet with no RxValid_o or RxError_o pulse; after release the block hunts for a new sync from IDLE.

Verification
REQ-030 Basic byte: line KJKJKJKK then the NRZI of 0xA5, then 2 bits SE0, then J -> RxActive_o rises on the last K; one RxValid_o pulse with DataIn_o = 0xA5; RxActive_o falls on the J.
REQ-031 Bit stuffing: sync then data 0xFF, with a stuffed 0 inserted after the 5th data 1 (the sync's final 1 counts toward the run) -> DataIn_o = 0xFF, RxError_o stays 0.
REQ-032 Stuff error: sync, then 6 consecutive decoded 1s followed by a decoded 1 -> one RxError_o pulse, no RxValid_o; RxActive_o stays 1 until SE0 then J, then drops.
REQ-033 Partial byte: sync, then 0x3C, then 3 bits, then EOP -> exactly one RxValid_o (0x3C); no error pulse.
REQ-034 False sync: only 5 decoded 0s followed by a 1 (SYNC_ZEROS = 6) -> RxActive_o stays 0; a following valid sync is still detected.
REQ-035 Reset mid-packet: rst low for one cycle after 4 data bits -> all outputs 0 immediately; the next full packet with byte 0x5A is received correctly.

Source files
------------

// File: rtl/usb_rx_phy.sv
// -----------------------------------------------------------------------------
// usb_rx_phy
//
// Receive half of a USB full/low-speed PHY back end.  Samples the line once per
// bit time (bit_en), NRZI-decodes it, hunts for the sync pattern, strips stuffed
// bits, assembles bytes LSB-first and reports packet framing and stuffing errors.
//
// Parameters
//   SYNC_ZEROS : minimum run of decoded 0s that must precede the decoded 1
//                closing the sync field.
//   STUFF_LEN  : run of decoded 1s after which the next bit is a stuffed bit.
//
// Ports
//   clk        in   1  rising-edge clock for all state
//   rst        in   1  asynchronous active-low reset
//   bit_en     in   1  one-clk sample strobe per bit time
//   rxd        in   1  received line level (1 = J, 0 = K), ignored during SE0
//   se0        in   1  single-ended-zero line state
//   DataIn_o   out  8  last fully received byte (held until the next one)
//   RxValid_o  out  1  one-clk pulse when DataIn_o is updated
//   RxActive_o out  1  high from sync detect until the end of EOP
//   RxError_o  out  1  one-clk pulse on a bit-stuff violation
// -----------------------------------------------------------------------------
module usb_rx_phy #(
    parameter int SYNC_ZEROS = 6,
    parameter int STUFF_LEN  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       rxd,
    input  logic       se0,
    output logic [7:0] DataIn_o,
    output logic       RxValid_o,
    output logic       RxActive_o,
    output logic       RxError_o
);

    localparam int ZW = $clog2(SYNC_ZEROS + 1);
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR  = 2'd2,
        ST_EOP  = 2'd3
    } state_t;

    state_t          state_reg,    state_next;
    logic            last_rxd_reg, last_rxd_next;
    logic [ZW-1:0]   zero_cnt_reg, zero_cnt_next;
    logic [OW-1:0]   ones_cnt_reg, ones_cnt_next;
    logic [2:0]      bit_cnt_reg,  bit_cnt_next;
    logic [7:0]      shift_reg,    shift_next;
    logic [7:0]      data_reg,     data_next;
    logic            valid_reg,    valid_next;
    logic            active_reg,   active_next;
    logic            error_reg,    error_next;

    // NRZI: no transition means a 1, a transition means a 0.
    logic       dec_bit;
    logic [7:0] byte_shifted;

    assign dec_bit = (rxd == last_rxd_reg);

    // Bytes arrive LSB-first, so each kept bit enters at the top and the
    // register slides right; after 8 kept bits bit 0 holds the first bit.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_shift
            assign byte_shifted[gi] = shift_reg[gi + 1];
        end
    endgenerate
    assign byte_shifted[7] = dec_bit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            last_rxd_reg <= 1'b1;
            zero_cnt_reg <= '0;
            ones_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= 8'h00;
            valid_reg    <= 1'b0;
            active_reg   <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_rxd_reg <= last_rxd_next;
            zero_cnt_reg <= zero_cnt_next;
            ones_cnt_reg <= ones_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            active_reg   <= active_next;
            error_reg    <= error_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        last_rxd_next = last_rxd_reg;
        zero_cnt_next = zero_cnt_reg;
        ones_cnt_next = ones_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        valid_next    = 1'b0;
        active_next   = active_reg;
        error_next    = 1'b0;

        if (bit_en) begin
            // SE0 leaves the line in J once it ends, so the decoder reference
            // is reset to J rather than to the ignored rxd value.
            last_rxd_next = se0 ? 1'b1 : rxd;

            case (state_reg)
                ST_IDLE: begin
                    if (!se0) begin
                        if (dec_bit) begin
                            if (zero_cnt_reg >= ZW'(SYNC_ZEROS)) begin
                                state_next    = ST_DATA;
                                active_next   = 1'b1;
                                // The 1 closing the sync already counts
                                // toward the stuffing run.
                                ones_cnt_next = OW'(1);
                                bit_cnt_next  = '0;
                            end
                            zero_cnt_next = '0;
                        end else if (zero_cnt_reg < ZW'(SYNC_ZEROS)) begin
                            zero_cnt_next = zero_cnt_reg + ZW'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (se0) begin
                        // Any partial byte is dropped without a pulse.
                        state_next = ST_EOP;
                    end else if (ones_cnt_reg == OW'(STUFF_LEN)) begin
                        // Stuff position: a 0 is discarded, a 1 is illegal.
                        if (dec_bit) begin
                            error_next = 1'b1;
                            state_next = ST_ERR;
                        end else begin
                            ones_cnt_next = '0;
                        end
                    end else begin
                        shift_next    = byte_shifted;
                        ones_cnt_next = dec_bit ? ones_cnt_reg + OW'(1) : '0;
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            data_next  = byte_shifted;
                            valid_next = 1'b1;
                        end
                    end
                end

                ST_ERR: begin
                    if (se0) begin
                        state_next = ST_EOP;
                    end
                end

                ST_EOP: begin
                    // The first non-SE0 bit ends the packet and is not used
                    // as part of the next sync hunt.
                    if (!se0) begin
                        state_next    = ST_IDLE;
                        active_next   = 1'b0;
                        zero_cnt_next = '0;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign DataIn_o   = data_reg;
    assign RxValid_o  = valid_reg;
    assign RxActive_o = active_reg;
    assign RxError_o  = error_reg;

endmodule
